// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one request at a time,
// programmable wait states, pipeline stall, error flagging and saturating access counters.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        addr_err,
    output logic        stall,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt;
    logic                    op_read_q, op_write_q, err_q;
    logic [DEPTH_LOG2-1:0]   word_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

    logic                    req, req_err, bypass, commit;
    logic                    acc_read, acc_write, acc_err;
    logic [DEPTH_LOG2-1:0]   acc_word;
    logic [31:0]             acc_wdata;
    logic [15:0]             rd_count_nxt, wr_count_nxt;

    assign req     = req_read | req_write;
    assign req_err = (req_addr[1:0] != 2'b00)
                  || ((req_addr >> (DEPTH_LOG2 + 2)) != '0)
                  || (req_read && req_write);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (wait_cnt == '0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With no wait states the commit edge is also the acceptance edge, so the
    // access is taken straight from the request inputs instead of the latches.
    assign bypass    = (state == ST_IDLE);
    assign acc_read  = bypass ? req_read  : op_read_q;
    assign acc_write = bypass ? req_write : op_write_q;
    assign acc_err   = bypass ? req_err   : err_q;
    assign acc_word  = bypass ? req_addr[DEPTH_LOG2+1:2] : word_q;
    assign acc_wdata = bypass ? req_wdata : wdata_q;
    assign commit    = (state_nxt == ST_DONE) && (state != ST_DONE);

    assign stall    = ((state == ST_IDLE) && req) || (state == ST_WAIT);
    assign done     = (state == ST_DONE);
    assign addr_err = (state == ST_DONE) && err_q;

    assign rd_count_nxt = (commit && acc_read && !acc_err && rd_count != 16'hFFFF)
                        ? rd_count + 16'd1 : rd_count;
    assign wr_count_nxt = (commit && acc_write && !acc_err && wr_count != 16'hFFFF)
                        ? wr_count + 16'd1 : wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            state    <= state_nxt;
            rd_count <= rd_count_nxt;
            wr_count <= wr_count_nxt;
            if ((state == ST_IDLE) && req) begin
                op_read_q  <= req_read;
                op_write_q <= req_write;
                err_q      <= req_err;
                word_q     <= req_addr[DEPTH_LOG2+1:2];
                wdata_q    <= req_wdata;
                wait_cnt   <= WAIT_INIT;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                if (acc_err)
                    rdata <= '0;
                else if (acc_read)
                    rdata <= mem[acc_word];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && acc_write && !acc_err)
            mem[acc_word] <= acc_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] addr2, wdata2, addr0, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        done2, done0, err2, err0, stall2, stall0;
    logic [15:0] rdc2, wrc2, rdc0, wrc0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req_read(rd2), .req_write(wr2),
        .req_addr(addr2), .req_wdata(wdata2), .rdata(rdata2), .done(done2),
        .addr_err(err2), .stall(stall2), .rd_count(rdc2), .wr_count(wrc2)
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_read(rd0), .req_write(wr0),
        .req_addr(addr0), .req_wdata(wdata0), .rdata(rdata0), .done(done0),
        .addr_err(err0), .stall(stall0), .rd_count(rdc0), .wr_count(wrc0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its done pulse, checking stall length and error flag.
    task automatic access(input bit sel0, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int exp_stall, input logic exp_err, input string tag);
        int   nstall = 0;
        int   ncyc   = 0;
        bit   got    = 0;
        logic s, d, e;
        if (sel0) begin rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data; end
        else      begin rd2 = rd; wr2 = wr; addr2 = addr; wdata2 = data; end
        for (int i = 0; i < 20; i++) begin
            #1;
            s = sel0 ? stall0 : stall2;
            d = sel0 ? done0  : done2;
            e = sel0 ? err0   : err2;
            if (d) begin
                got  = 1;
                ncyc = i;
                break;
            end
            if (s) nstall++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_stall_cycles"}, nstall, exp_stall);
        chk({tag, "_done_latency"}, ncyc, exp_stall);
        chk({tag, "_stall_in_done"}, 32'(s), 32'd0);
        chk({tag, "_addr_err"}, 32'(e), 32'(exp_err));
        if (sel0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else      begin rd2 = 1'b0; wr2 = 1'b0; end
        @(negedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(sel0 ? done0 : done2), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_err2", 32'(err2), 32'd0);
        chk("rst_stall2", 32'(stall2), 32'd0);
        chk("rst_rdc2", 32'(rdc2), 32'd0);
        chk("rst_wrc2", 32'(wrc2), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdc0", 32'(rdc0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, "st10");
        chk("st10_wrc", 32'(wrc2), 32'd1);
        chk("st10_rdc", 32'(rdc2), 32'd0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, "ld10");
        chk("ld10_rdata", rdata2, 32'hDEADBEEF);
        chk("ld10_rdc", 32'(rdc2), 32'd1);
        access(0, 1'b0, 1'b1, 32'h20, 32'h5555AAAA, 3, 1'b0, "st20");
        chk("st20_rdata_hold", rdata2, 32'hDEADBEEF);
        chk("st20_wrc", 32'(wrc2), 32'd2);

        access(0, 1'b0, 1'b1, 32'h13, 32'hCAFEF00D, 3, 1'b1, "st13_misalign");
        chk("st13_wrc", 32'(wrc2), 32'd2);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, "ld10b");
        chk("ld10b_rdata", rdata2, 32'hDEADBEEF);
        chk("ld10b_rdc", 32'(rdc2), 32'd2);

        access(0, 1'b1, 1'b0, 32'h400, 32'h0, 3, 1'b1, "ld400_range");
        chk("ld400_rdata", rdata2, 32'd0);
        chk("ld400_rdc", 32'(rdc2), 32'd2);
        access(0, 1'b1, 1'b1, 32'h20, 32'h11111111, 3, 1'b1, "rw20_conflict");
        chk("rw20_rdata", rdata2, 32'd0);
        chk("rw20_rdc", 32'(rdc2), 32'd2);
        chk("rw20_wrc", 32'(wrc2), 32'd2);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0, "ld20");
        chk("ld20_rdata", rdata2, 32'h5555AAAA);
        chk("ld20_rdc", 32'(rdc2), 32'd3);

        // Reset lands in the second WAIT cycle, right before the would-be commit edge.
        access(0, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 3, 1'b0, "st40_prior");
        rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'h40; wdata2 = 32'hA5A5A5A5;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_stall_wait2", 32'(stall2), 32'd1);
        reset = 1'b1;
        wr2 = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_stall", 32'(stall2), 32'd0);
        chk("abort_done", 32'(done2), 32'd0);
        chk("abort_wrc", 32'(wrc2), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 3, 1'b0, "ld40");
        chk("ld40_rdata", rdata2, 32'h0BADF00D);
        chk("ld40_rdc", 32'(rdc2), 32'd1);

        access(1, 1'b0, 1'b1, 32'h3FC, 32'h12345678, 1, 1'b0, "w0_st3fc");
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1, 1'b0, "w0_ld3fc");
        chk("w0_ld3fc_rdata", rdata0, 32'h12345678);
        chk("w0_rdc", 32'(rdc0), 32'd1);
        chk("w0_wrc", 32'(wrc0), 32'd1);

        @(negedge clk);
        force u_w0.rd_count_nxt = 16'hFFFE;
        @(negedge clk);
        release u_w0.rd_count_nxt;
        #1;
        chk("sat_preset", 32'(rdc0), 32'h0000FFFE);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1, 1'b0, "sat_ld1");
        chk("sat_rdc1", 32'(rdc0), 32'h0000FFFF);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1, 1'b0, "sat_ld2");
        chk("sat_rdc2", 32'(rdc0), 32'h0000FFFF);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1, 1'b0, "sat_ld3");
        chk("sat_rdc3", 32'(rdc0), 32'h0000FFFF);
        chk("sat_wrc", 32'(wrc0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
